// File: rtl/sar_sched_pkg.sv
// Shared state encoding and default sizing for the SAR conversion scheduler.
package sar_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      GAP  = 2'd2,
      PUSH = 2'd3
   } sched_state_t;

   localparam int DEF_NBITS       = 10;
   localparam int DEF_AVG_LOG2    = 2;
   localparam int DEF_PERIOD_W    = 16;
   localparam int DEF_TIMEOUT_CYC = 64;
   localparam int DEF_FIFO_DEPTH  = 4;

endpackage

// File: rtl/sar_result_fifo.sv
// Result buffer with a registered head; a push and a pop may share a cycle, so a full FIFO
// still accepts a push when the head is popped. New head appears one cycle after the write/pop.
module sar_result_fifo
   import sar_sched_pkg::*;
#(
   parameter int WIDTH = DEF_NBITS,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] head_dat,
   output logic             head_vld,
   output logic             full
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    rd_next;
   logic [PW:0]      cnt;
   logic [PW:0]      cnt_next;
   logic             pop;
   logic             wr_en;

   assign full    = (cnt == FULL_CNT);
   assign pop     = head_vld && pop_rdy;
   assign wr_en   = push && (!full || pop);
   assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

   always_comb begin
      cnt_next = cnt;
      if (wr_en && !pop) begin
         cnt_next = cnt + 1'b1;
      end else if (pop && !wr_en) begin
         cnt_next = cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         head_vld <= 1'b0;
         head_dat <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         rd_ptr   <= rd_next;
         cnt      <= cnt_next;
         head_vld <= (cnt_next != '0);
         // The slot being written this cycle can only become head when it is the next read slot.
         if (cnt_next == '0) begin
            head_dat <= '0;
         end else if (wr_en && (wr_ptr == rd_next)) begin
            head_dat <= push_dat;
         end else begin
            head_dat <= mem[rd_next];
         end
      end
   end

endmodule

// File: rtl/sar_conv_scheduler.sv
// Launches SAR conversions at a programmable period, averages 2^AVG_LOG2 results and queues them;
// results appear two cycles after the last EOC of a group, and a full queue drops results (OVERRUN).
module sar_conv_scheduler
   import sar_sched_pkg::*;
#(
   parameter int NBITS       = DEF_NBITS,
   parameter int AVG_LOG2    = DEF_AVG_LOG2,
   parameter int PERIOD_W    = DEF_PERIOD_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                START,
   input  logic                CONT,
   input  logic [PERIOD_W-1:0] PERIOD,
   input  logic                SAR_EOC,
   input  logic [0:NBITS-1]    SAR_DOUT,
   output logic                SAR_ENABLE,
   output logic [NBITS-1:0]    RES_DATA,
   output logic                RES_VALID,
   input  logic                RES_READY,
   output logic                BUSY,
   output logic                OVERRUN,
   output logic                TIMEOUT
);

   localparam int ACC_W = NBITS + AVG_LOG2;
   localparam int GRP_W = AVG_LOG2 + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'((1 << AVG_LOG2) - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

   sched_state_t        state;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] pcnt;
   logic [PERIOD_W:0]   pcnt_inc;
   logic                period_done;
   logic [TO_W-1:0]     tcnt;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_sum;
   logic [GRP_W-1:0]    grp;
   logic [NBITS-1:0]    dout_lsb;
   logic [NBITS-1:0]    push_dat;
   logic                fifo_full;

   always_comb begin
      dout_lsb = '0;
      for (int i = 0; i < NBITS; i++) begin
         dout_lsb[NBITS-1-i] = SAR_DOUT[i];
      end
   end

   assign acc_sum  = acc + ACC_W'(dout_lsb);
   assign push_dat = acc[ACC_W-1:AVG_LOG2];

   // pcnt counts cycles since the last SAR_ENABLE rise; the next rise is due once it reaches PERIOD-1.
   assign pcnt_inc    = {1'b0, pcnt} + 1'b1;
   assign period_done = (pcnt_inc >= {1'b0, period_q});

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         SAR_ENABLE <= 1'b0;
         BUSY       <= 1'b0;
         OVERRUN    <= 1'b0;
         TIMEOUT    <= 1'b0;
         period_q   <= '0;
         pcnt       <= '0;
         tcnt       <= '0;
         acc        <= '0;
         grp        <= '0;
      end else begin
         if (pcnt != '1) begin
            pcnt <= pcnt + 1'b1;
         end
         case (state)
            IDLE: begin
               if (START) begin
                  state      <= CONV;
                  SAR_ENABLE <= 1'b1;
                  BUSY       <= 1'b1;
                  period_q   <= PERIOD;
                  pcnt       <= '0;
                  tcnt       <= '0;
                  acc        <= '0;
                  grp        <= '0;
                  OVERRUN    <= 1'b0;
                  TIMEOUT    <= 1'b0;
               end
            end
            CONV: begin
               if (SAR_EOC) begin
                  acc        <= acc_sum;
                  grp        <= grp + 1'b1;
                  SAR_ENABLE <= 1'b0;
                  state      <= (grp == GRP_LAST) ? PUSH : GAP;
               end else if (tcnt == TO_LAST) begin
                  state      <= IDLE;
                  SAR_ENABLE <= 1'b0;
                  BUSY       <= 1'b0;
                  TIMEOUT    <= 1'b1;
                  acc        <= '0;
                  grp        <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            GAP: begin
               if (period_done) begin
                  state      <= CONV;
                  SAR_ENABLE <= 1'b1;
                  pcnt       <= '0;
                  tcnt       <= '0;
               end
            end
            PUSH: begin
               acc <= '0;
               grp <= '0;
               if (fifo_full && !(RES_VALID && RES_READY)) begin
                  OVERRUN <= 1'b1;
               end
               if (CONT) begin
                  state <= GAP;
               end else begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               SAR_ENABLE <= 1'b0;
               BUSY       <= 1'b0;
            end
         endcase
      end
   end

   sar_result_fifo #(
      .WIDTH (NBITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst      (RST),
      .push     (state == PUSH),
      .push_dat (push_dat),
      .pop_rdy  (RES_READY),
      .head_dat (RES_DATA),
      .head_vld (RES_VALID),
      .full     (fifo_full)
   );

endmodule

// File: tb/tb_sar_conv_scheduler.sv
// Randomised bench: a SAR model answers SAR_ENABLE, and a queue-level model of averaging,
// buffering, overrun and launch spacing is compared against the scheduler every cycle.
module tb_sar_conv_scheduler;

   localparam int AVG_N = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       cont;
   logic [15:0] period;
   logic       sar_eoc;
   logic [0:9] sar_dout;
   logic       sar_enable;
   logic [9:0] res_data;
   logic       res_valid;
   logic       res_ready;
   logic       busy;
   logic       overrun;
   logic       timeout;

   sar_conv_scheduler dut (
      .CLK        (clk),
      .RST        (rst),
      .START      (start),
      .CONT       (cont),
      .PERIOD     (period),
      .SAR_EOC    (sar_eoc),
      .SAR_DOUT   (sar_dout),
      .SAR_ENABLE (sar_enable),
      .RES_DATA   (res_data),
      .RES_VALID  (res_valid),
      .RES_READY  (res_ready),
      .BUSY       (busy),
      .OVERRUN    (overrun),
      .TIMEOUT    (timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // model state
   bit  mon_on = 0;
   int  conv_t = 8;
   bit  no_eoc = 0;
   int  dout_mode = 0;
   int  dout_fix = 0;
   int  dout_q[$];
   int  rdy_mode = 2;
   int  m_period = 0;
   int  en_cnt = 0;
   int  last_hi = 0;
   bit  prev_en = 0;
   int  last_rise = -1;
   int  exp_gap = 0;
   int  grp_sum = 0;
   int  grp_n = 0;
   int  push_at[$];
   int  push_val[$];
   int  mq[$];
   bit  m_ovr = 0;
   int  n_push = 0;
   int  pop_log[$];

   initial begin
      int v;
      sar_eoc   = 1'b0;
      sar_dout  = '0;
      res_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            check("res_valid", res_valid, mq.size() > 0);
            if (mq.size() > 0) check("res_data", res_data, mq[0]);
            check("overrun", overrun, m_ovr);
            if (sar_enable && !prev_en) begin
               if (last_rise >= 0) check("enable_period", cyc - last_rise, exp_gap);
               last_rise = cyc;
            end
            if (!sar_enable && prev_en) last_hi = en_cnt;
            en_cnt  = sar_enable ? en_cnt + 1 : 0;
            prev_en = sar_enable;

            sar_eoc = 1'b0;
            if (!rst && sar_enable && !no_eoc && en_cnt == conv_t) begin
               if (dout_mode == 1) v = dout_fix;
               else if (dout_mode == 2 && dout_q.size() > 0) v = dout_q.pop_front();
               else v = $urandom_range(0, 1023);
               sar_dout = v[9:0];
               sar_eoc  = 1'b1;
               grp_sum += v;
               grp_n++;
               if (grp_n == AVG_N) begin
                  push_at.push_back(cyc + 2);
                  push_val.push_back(grp_sum / AVG_N);
                  grp_sum = 0;
                  grp_n   = 0;
                  exp_gap = (m_period > conv_t + 2) ? m_period : conv_t + 2;
               end else begin
                  exp_gap = (m_period > conv_t + 1) ? m_period : conv_t + 1;
               end
            end

            case (rdy_mode)
               0: res_ready = 1'b0;
               1: res_ready = 1'($urandom_range(0, 1));
               3: res_ready = (push_at.size() > 0 && push_at[0] == cyc + 1);
               default: res_ready = 1'b1;
            endcase

            if (rst) begin
               mq.delete();
               push_at.delete();
               push_val.delete();
               m_ovr     = 0;
               grp_sum   = 0;
               grp_n     = 0;
               last_rise = -1;
            end else begin
               if (res_ready && mq.size() > 0) begin
                  pop_log.push_back(int'(res_data));
                  void'(mq.pop_front());
               end
               if (push_at.size() > 0 && push_at[0] == cyc + 1) begin
                  void'(push_at.pop_front());
                  v = push_val.pop_front();
                  n_push++;
                  if (mq.size() < DEPTH) mq.push_back(v);
                  else m_ovr = 1;
               end
               if (start) begin
                  m_ovr     = 0;
                  grp_sum   = 0;
                  grp_n     = 0;
                  last_rise = -1;
                  m_period  = int'(period);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_start(input int per, input bit c);
      period = per[15:0];
      cont   = c;
      start  = 1'b1;
      tick(1);
      start  = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int k = 0;
      tick(1);
      while (busy !== 1'b0 && k < bound) begin
         tick(1);
         k++;
      end
      check(tag, busy, 0);
   endtask

   task automatic wait_pushes(input int cnt, input int bound);
      int base = n_push;
      int k = 0;
      while (n_push < base + cnt && k < bound) begin
         tick(1);
         k++;
      end
      tick(2);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_enable"}, sar_enable, 0);
      check({tag, "_valid"}, res_valid, 0);
      check({tag, "_data"}, res_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_timeout"}, timeout, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst    = 1'b1;
      start  = 1'b0;
      cont   = 1'b0;
      period = 16'd20;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      rst    = 1'b0;
      mon_on = 1;
      tick(2);

      // single group of identical samples
      conv_t = 12; dout_mode = 1; dout_fix = 'h201; rdy_mode = 0;
      pop_log.delete();
      pulse_start(20, 0);
      check("a_busy_on_start", busy, 1);
      check("a_enable_on_start", sar_enable, 1);
      wait_idle("a_idle", 400);
      tick(2);
      check("a_result_held", res_valid, 1);
      rdy_mode = 2;
      tick(3);
      check("a_result_count", pop_log.size(), 1);
      if (pop_log.size() > 0) check("a_result_data", pop_log[0], 'h201);

      // continuous mode, known average, 30-cycle launch spacing
      dout_mode = 2; dout_q = '{100, 101, 102, 104}; conv_t = 12;
      pop_log.delete();
      pulse_start(30, 1);
      wait_pushes(1, 1000);
      cont = 1'b0;
      wait_idle("b_idle", 1000);
      tick(3);
      check("b_result_count", pop_log.size(), 2);
      if (pop_log.size() > 0) check("b_average", pop_log[0], 101);

      // period shorter than a conversion: minimal gaps
      dout_mode = 0; conv_t = 12; rdy_mode = 1;
      pulse_start(2, 1);
      tick(200);
      cont = 1'b0;
      wait_idle("c_idle", 400);
      rdy_mode = 2;
      tick(8);
      check("c_drained", res_valid, 0);

      // fill, pop-with-push on full, then a real overrun
      conv_t = 4; rdy_mode = 0;
      pulse_start(10, 1);
      k = 0;
      while (mq.size() < DEPTH && k < 2000) begin
         tick(1);
         k++;
      end
      check("d_full_valid", res_valid, 1);
      rdy_mode = 3;
      wait_pushes(2, 1000);
      check("d_pop_on_push_no_overrun", overrun, 0);
      rdy_mode = 0;
      wait_pushes(1, 1000);
      check("d_overrun", overrun, 1);
      cont = 1'b0;
      wait_idle("d_idle", 1000);
      check("d_overrun_sticky", overrun, 1);
      rdy_mode = 2;
      tick(10);
      check("d_drained", res_valid, 0);

      // conversion timeout, then a fresh start clears the flag
      no_eoc = 1;
      pulse_start(20, 0);
      check("e_overrun_cleared", overrun, 0);
      wait_idle("e_idle", 200);
      tick(1);
      check("e_enable_high_cycles", last_hi, 64);
      check("e_timeout_set", timeout, 1);
      check("e_enable_low", sar_enable, 0);
      no_eoc = 0;
      pulse_start(20, 0);
      check("e_timeout_cleared", timeout, 0);
      wait_idle("e2_idle", 400);
      tick(6);

      // reset mid-conversion with two results buffered
      conv_t = 6; rdy_mode = 0;
      pulse_start(12, 1);
      k = 0;
      while (!(mq.size() == 2 && sar_enable === 1'b1) && k < 2000) begin
         tick(1);
         k++;
      end
      check("f_two_buffered", res_valid, 1);
      rst = 1'b1;
      tick(1);
      check_reset_outputs("f_reset");
      rst  = 1'b0;
      cont = 1'b0;
      tick(3);
      check("f_idle_after_reset", busy, 0);
      check("f_empty_after_reset", res_valid, 0);

      // randomised runs
      for (int r = 0; r < 6; r++) begin
         conv_t    = $urandom_range(1, 20);
         rdy_mode  = 1;
         dout_mode = 0;
         pulse_start($urandom_range(0, 40), 1);
         tick($urandom_range(100, 400));
         cont = 1'b0;
         wait_idle("rnd_idle", 2000);
         rdy_mode = 2;
         tick(8);
         check("rnd_drained", res_valid, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sar_conv_scheduler.md
# sar_conv_scheduler

Conversion scheduler for the 10-bit SAR ADC controller. It drives the SAR `ENABLE` input to launch conversions at a programmable period and captures `DOUT` on each `EOC`. It averages 2^AVG_LOG2 conversions per result and buffers the results in a small FIFO behind a valid/ready handshake. It sits between the `sar_controller` instance and the digital consumer (register bank / streaming sink).

## Interface
- `NBITS`, 10: SAR resolution.
- `AVG_LOG2`, 2: log2 of conversions averaged per result. Range 0..4.
- `PERIOD_W`, 16: width of the conversion-period register.
- `TIMEOUT_CYC`, 64: max cycles with `SAR_ENABLE` high before `EOC` is required.
- `FIFO_DEPTH`, 4: result buffer entries. Power of 2.

Ports:
- `CLK` in 1: clock. Rising edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: one-cycle pulse that starts scheduling. Ignored while `BUSY`.
- `CONT` in 1: level signal. 1 = repeat groups until deasserted; 0 = one group.
- `PERIOD` in PERIOD_W: cycles between successive `SAR_ENABLE` rising edges. Sampled on accepted `START`.
- `SAR_EOC` in 1: end-of-conversion from the SAR controller.
- `SAR_DOUT` in [0:NBITS-1]: SAR result. Index 0 is the MSB.
- `SAR_ENABLE` out 1: SAR controller enable.
- `RES_DATA` out NBITS: averaged result, MSB at NBITS-1. Drives the FIFO head.
- `RES_VALID` out 1: FIFO not empty.
- `RES_READY` in 1: consumer pop. Transfer occurs when `RES_VALID && RES_READY`.
- `BUSY` out 1: state ≠ IDLE.
- `OVERRUN` out 1: sticky flag. A result was dropped because the FIFO was full.
- `TIMEOUT` out 1: sticky flag. A conversion exceeded `TIMEOUT_CYC`.

## Operation
- States:
  - IDLE: waits for `START`.
  - CONV: `SAR_ENABLE`=1, waiting for `EOC`.
  - GAP: `SAR_ENABLE`=0, waiting for the period to expire.
  - PUSH: writes the averaged result to the FIFO.
- IDLE, `START`=1 → CONV. This latches `PERIOD`, clears the accumulator, the group count, `OVERRUN` and `TIMEOUT`.
- CONV, `SAR_EOC`=1 → `acc += SAR_DOUT` (bit-reversed to LSB-first). The group count increments.
  - If the count reaches 2^AVG_LOG2 → PUSH.
  - Otherwise → GAP.
- CONV, timeout counter reaches `TIMEOUT_CYC` with no `EOC` → IDLE. `TIMEOUT` is set and the accumulator is discarded.
- GAP → CONV when the period counter, which started at the last `SAR_ENABLE` rise, reaches `PERIOD`-1. GAP always lasts at least 1 cycle, which resets the SAR. If `PERIOD` is smaller than the conversion time + 1, the next CONV starts after exactly 1 GAP cycle.
- PUSH writes `acc >> AVG_LOG2` (truncating) to the FIFO and clears the accumulator and count.
  - If `CONT`=1 → GAP.
  - Otherwise → IDLE.
- PUSH with FIFO full and no pop in the same cycle: the result is dropped and `OVERRUN` is set. If a pop occurs in the same cycle, the push succeeds.
- Accumulator width is NBITS+AVG_LOG2. Overflow is impossible.
- Deasserting `CONT` mid-group: the current group finishes, then the block goes to IDLE after PUSH.
- `EOC` outside CONV is ignored.
- FIFO contents persist across IDLE. Only `RST` flushes them.

## Timing
- Reset values: `SAR_ENABLE`=0, `RES_VALID`=0, `RES_DATA`=0, `BUSY`=0, `OVERRUN`=0, `TIMEOUT`=0. State is IDLE and the FIFO is empty.
- `RST` mid-conversion: `SAR_ENABLE` goes low on the next edge and all state is discarded.
- `START` accepted at edge N → `SAR_ENABLE`=1 and `BUSY`=1 from edge N+1.
- `SAR_DOUT` is sampled in the same cycle as `SAR_EOC`. `SAR_ENABLE` drops on the next edge.
- Last `EOC` of a group at edge N → PUSH during cycle N+1 → `RES_VALID`=1 from edge N+2. There is no bypass path.
- Pop at edge N → `RES_VALID`/`RES_DATA` reflect the new head from edge N+1.
- All outputs are registered.

## Structure
- Package `sar_sched_pkg`: state enum (IDLE, CONV, GAP, PUSH) and default parameter constants.
- Sub-module `sar_result_fifo`: synchronous FIFO with registered head, full/empty flags, and simultaneous push/pop. The scheduler FSM, period counter, timeout counter and accumulator live in the top module.

## Test plan
- AVG_LOG2=0, `PERIOD`=20, `CONT`=0. `START`, then the SAR model returns `DOUT`=10'b1000000001 → exactly one result 0x201, `RES_VALID` 2 cycles after `EOC`, `BUSY` low after PUSH.
- AVG_LOG2=2, `CONT`=1, `PERIOD`=30. Conversions return 100, 101, 102, 104 → `RES_DATA`=101. `SAR_ENABLE` rises every 30 cycles.
- `PERIOD`=2 with a 12-cycle conversion → every GAP is exactly 1 cycle and no conversion overlaps.
- `RES_READY`=0 with `CONT`=1 → 4 results buffered. The 5th is dropped and `OVERRUN`=1. A pop in the same cycle as PUSH on a full FIFO gives no overrun.
- SAR model never asserts `EOC` → after 64 cycles `SAR_ENABLE`=0, `TIMEOUT`=1, state IDLE. A new `START` clears `TIMEOUT`.
- `RST` asserted during CONV with 2 results buffered → next cycle all outputs are at reset values and the FIFO is empty.
